vscale_ex_wb_stage: RTL and testbench

VSCALE_EX_WB_STAGE -- requirements
Module: vscale_ex_wb_stage

---
 rtl/vscale_ex_wb_stage_pkg.sv | 7 +
 rtl/vscale_bypass_unit.sv | 16 +
 rtl/vscale_ex_wb_stage.sv | 97 +++++++++
 tb/tb_vscale_ex_wb_stage.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/vscale_ex_wb_stage_pkg.sv
// vscale_ex_wb_stage_pkg: shared control constants for the EX/WB pipeline boundary
package vscale_ex_wb_stage_pkg;
    localparam logic [1:0] WB_SRC_ALU = 2'd0;
    localparam logic [1:0] WB_SRC_PC4 = 2'd1;
    localparam logic [1:0] WB_SRC_CSR = 2'd2;
    localparam logic [1:0] WB_SRC_MEM = 2'd3;
endpackage

// File: rtl/vscale_bypass_unit.sv
// vscale_bypass_unit: one operand's WB->EX forwarding compare and mux
module vscale_bypass_unit #(
    parameter int XLEN     = 32,
    parameter int RA_WIDTH = 5
) (
    input  logic [RA_WIDTH-1:0] rs_addr,
    input  logic [XLEN-1:0]     rf_data,
    input  logic                wb_hit_en,
    input  logic [RA_WIDTH-1:0] wb_addr,
    input  logic [XLEN-1:0]     wb_data,
    output logic [XLEN-1:0]     fwd
);
    always_comb
        fwd = (rs_addr == '0) ? '0 :
              (wb_hit_en && wb_addr == rs_addr) ? wb_data : rf_data;
endmodule

// File: rtl/vscale_ex_wb_stage.sv
// vscale_ex_wb_stage: EX->WB pipeline register, writeback mux, bypass and retire counter
module vscale_ex_wb_stage
    import vscale_ex_wb_stage_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int RA_WIDTH = 5
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                ex_valid,
    input  logic                ex_kill,
    input  logic [XLEN-1:0]     ex_alu_out,
    input  logic [XLEN-1:0]     ex_pc_plus4,
    input  logic [XLEN-1:0]     ex_csr_rdata,
    input  logic [1:0]          ex_wb_src_sel,
    input  logic                ex_wr_reg,
    input  logic [RA_WIDTH-1:0] ex_rd_addr,
    input  logic [RA_WIDTH-1:0] ex_rs1_addr,
    input  logic [RA_WIDTH-1:0] ex_rs2_addr,
    input  logic [XLEN-1:0]     ex_rs1_rf,
    input  logic [XLEN-1:0]     ex_rs2_rf,
    input  logic [XLEN-1:0]     dmem_rdata,
    input  logic                dmem_wait,
    output logic [XLEN-1:0]     ex_rs1_fwd,
    output logic [XLEN-1:0]     ex_rs2_fwd,
    output logic                stall_ex,
    output logic                wb_wen,
    output logic [RA_WIDTH-1:0] wb_waddr,
    output logic [XLEN-1:0]     wb_wdata,
    output logic                wb_retire,
    output logic [63:0]         instret
);
    logic            wb_valid;
    logic            wb_wr_reg;
    logic [1:0]      wb_src_sel;
    logic [XLEN-1:0] wb_alu_out;
    logic [XLEN-1:0] wb_pc_plus4;
    logic [XLEN-1:0] wb_csr_rdata;
    logic [63:0]     instret_cnt;
    logic            stall_wb;

    assign stall_wb  = wb_valid & (wb_src_sel == WB_SRC_MEM) & dmem_wait;
    assign stall_ex  = stall_wb;
    assign wb_retire = wb_valid & ~stall_wb;
    assign wb_wen    = wb_valid & wb_wr_reg & ~stall_wb & (wb_waddr != '0);
    assign instret   = instret_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n)
            wb_valid <= 1'b0;
        else if (!stall_wb)
            wb_valid <= ex_valid & ~ex_kill;
    end

    // Datapath fields carry no reset; they are qualified by wb_valid.
    always_ff @(posedge clk) begin
        if (!stall_wb) begin
            wb_src_sel   <= ex_wb_src_sel;
            wb_wr_reg    <= ex_wr_reg;
            wb_waddr     <= ex_rd_addr;
            wb_alu_out   <= ex_alu_out;
            wb_pc_plus4  <= ex_pc_plus4;
            wb_csr_rdata <= ex_csr_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            instret_cnt <= '0;
        else if (wb_retire)
            instret_cnt <= instret_cnt + 64'd1;
    end

    always_comb
        wb_wdata = (wb_src_sel == WB_SRC_ALU) ? wb_alu_out :
                   (wb_src_sel == WB_SRC_PC4) ? wb_pc_plus4 :
                   (wb_src_sel == WB_SRC_CSR) ? wb_csr_rdata : dmem_rdata;

    // A stalled load forwards unsettled dmem_rdata; stall_ex holds EX until it is valid.
    vscale_bypass_unit #(.XLEN(XLEN), .RA_WIDTH(RA_WIDTH)) u_bypass_rs1 (
        .rs_addr   (ex_rs1_addr),
        .rf_data   (ex_rs1_rf),
        .wb_hit_en (wb_valid & wb_wr_reg),
        .wb_addr   (wb_waddr),
        .wb_data   (wb_wdata),
        .fwd       (ex_rs1_fwd)
    );

    vscale_bypass_unit #(.XLEN(XLEN), .RA_WIDTH(RA_WIDTH)) u_bypass_rs2 (
        .rs_addr   (ex_rs2_addr),
        .rf_data   (ex_rs2_rf),
        .wb_hit_en (wb_valid & wb_wr_reg),
        .wb_addr   (wb_waddr),
        .wb_data   (wb_wdata),
        .fwd       (ex_rs2_fwd)
    );
endmodule

// File: tb/tb_vscale_ex_wb_stage.sv
// tb_vscale_ex_wb_stage: directed self-checking bench for the EX/WB stage
module tb_vscale_ex_wb_stage;
    import vscale_ex_wb_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ex_valid, ex_kill, ex_wr_reg, dmem_wait;
    logic [31:0] ex_alu_out, ex_pc_plus4, ex_csr_rdata, ex_rs1_rf, ex_rs2_rf, dmem_rdata;
    logic [1:0]  ex_wb_src_sel;
    logic [4:0]  ex_rd_addr, ex_rs1_addr, ex_rs2_addr;
    logic [31:0] ex_rs1_fwd, ex_rs2_fwd, wb_wdata;
    logic        stall_ex, wb_wen, wb_retire;
    logic [4:0]  wb_waddr;
    logic [63:0] instret;
    logic [63:0] exp_instret;
    int checks = 0;
    int failures = 0;

    vscale_ex_wb_stage #(.XLEN(32), .RA_WIDTH(5)) dut (
        .clk(clk), .reset_n(reset_n), .ex_valid(ex_valid), .ex_kill(ex_kill),
        .ex_alu_out(ex_alu_out), .ex_pc_plus4(ex_pc_plus4), .ex_csr_rdata(ex_csr_rdata),
        .ex_wb_src_sel(ex_wb_src_sel), .ex_wr_reg(ex_wr_reg), .ex_rd_addr(ex_rd_addr),
        .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
        .ex_rs1_rf(ex_rs1_rf), .ex_rs2_rf(ex_rs2_rf),
        .dmem_rdata(dmem_rdata), .dmem_wait(dmem_wait),
        .ex_rs1_fwd(ex_rs1_fwd), .ex_rs2_fwd(ex_rs2_fwd), .stall_ex(stall_ex),
        .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .wb_retire(wb_retire), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        ex_valid = 0; ex_kill = 0; ex_wr_reg = 0; ex_wb_src_sel = WB_SRC_ALU;
        ex_alu_out = 0; ex_pc_plus4 = 0; ex_csr_rdata = 0; ex_rd_addr = 0;
        ex_rs1_addr = 0; ex_rs2_addr = 0; ex_rs1_rf = 0; ex_rs2_rf = 0;
        dmem_rdata = 0; dmem_wait = 0;
    endtask

    task automatic issue(input logic [1:0] src, input logic [4:0] rd, input logic [31:0] val);
        idle();
        ex_valid = 1; ex_wr_reg = 1; ex_wb_src_sel = src; ex_rd_addr = rd;
        ex_alu_out = val; ex_pc_plus4 = val; ex_csr_rdata = val;
    endtask

    task automatic test_reset;
        reset_n = 0; idle();
        tick(); tick();
        reset_n = 1;
        #1;
        checks += 4;
        if (wb_wen !== 1'b0) begin failures++; $display("FAIL reset_wen got=%b exp=0", wb_wen); end
        if (wb_retire !== 1'b0) begin failures++; $display("FAIL reset_retire got=%b exp=0", wb_retire); end
        if (stall_ex !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_ex); end
        if (instret !== 64'd0) begin failures++; $display("FAIL reset_instret got=%0d exp=0", instret); end
        exp_instret = 0;
    endtask

    task automatic test_alu_back_to_back;
        issue(WB_SRC_ALU, 5'd5, 32'h10);
        tick();
        issue(WB_SRC_ALU, 5'd6, 32'h20);
        ex_rs1_addr = 5; ex_rs2_addr = 5; ex_rs1_rf = 32'hBAD; ex_rs2_rf = 32'hBAD;
        #1;
        checks += 4;
        if (ex_rs1_fwd !== 32'h10) begin failures++; $display("FAIL b2b_rs1_fwd got=%h exp=10", ex_rs1_fwd); end
        if (ex_rs2_fwd !== 32'h10) begin failures++; $display("FAIL b2b_rs2_fwd got=%h exp=10", ex_rs2_fwd); end
        if (wb_wen !== 1'b1 || wb_waddr !== 5'd5) begin failures++; $display("FAIL b2b_wr_x5 got=%b/%0d exp=1/5", wb_wen, wb_waddr); end
        if (wb_retire !== 1'b1) begin failures++; $display("FAIL b2b_retire got=%b exp=1", wb_retire); end
        exp_instret++;
        tick();
        idle();
        ex_rs1_addr = 6; ex_rs2_addr = 5; ex_rs1_rf = 32'h111; ex_rs2_rf = 32'h777;
        #1;
        checks += 4;
        if (wb_wdata !== 32'h20) begin failures++; $display("FAIL b2b_wdata got=%h exp=20", wb_wdata); end
        if (wb_waddr !== 5'd6 || wb_wen !== 1'b1) begin failures++; $display("FAIL b2b_waddr got=%0d/%b exp=6/1", wb_waddr, wb_wen); end
        if (ex_rs1_fwd !== 32'h20) begin failures++; $display("FAIL b2b_indep_rs1 got=%h exp=20", ex_rs1_fwd); end
        if (ex_rs2_fwd !== 32'h777) begin failures++; $display("FAIL b2b_indep_rs2 got=%h exp=777", ex_rs2_fwd); end
        exp_instret++;
        tick();
        checks++;
        if (instret !== exp_instret) begin failures++; $display("FAIL b2b_instret got=%0d exp=%0d", instret, exp_instret); end
    endtask

    task automatic test_wb_sources;
        issue(WB_SRC_PC4, 5'd1, 32'h104);
        ex_alu_out = 32'h1; ex_csr_rdata = 32'h2;
        tick();
        issue(WB_SRC_CSR, 5'd2, 32'hABC);
        ex_alu_out = 32'h3; ex_pc_plus4 = 32'h4;
        #1;
        checks++;
        if (wb_wdata !== 32'h104) begin failures++; $display("FAIL src_pc4 got=%h exp=104", wb_wdata); end
        exp_instret++;
        tick();
        idle();
        #1;
        checks++;
        if (wb_wdata !== 32'hABC) begin failures++; $display("FAIL src_csr got=%h exp=abc", wb_wdata); end
        exp_instret++;
        tick();
    endtask

    task automatic test_load_wait;
        int stalls = 0;
        issue(WB_SRC_MEM, 5'd7, 32'h0);
        dmem_wait = 1;
        tick();
        idle();
        dmem_wait = 1; dmem_rdata = 32'h0BAD0BAD; ex_rs1_addr = 7; ex_rs1_rf = 32'h5;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (stall_ex !== 1'b1 || wb_wen !== 1'b0 || wb_retire !== 1'b0) begin
                failures++; $display("FAIL load_stall%0d got stall=%b wen=%b ret=%b exp=1/0/0", i, stall_ex, wb_wen, wb_retire);
            end
            if (stall_ex === 1'b1) stalls++;
            tick();
        end
        dmem_wait = 0; dmem_rdata = 32'hDEADBEEF;
        #1;
        checks += 4;
        if (stalls != 3) begin failures++; $display("FAIL load_stall_cycles got=%0d exp=3", stalls); end
        if (stall_ex !== 1'b0) begin failures++; $display("FAIL load_release got=%b exp=0", stall_ex); end
        if (wb_wen !== 1'b1 || wb_waddr !== 5'd7 || wb_wdata !== 32'hDEADBEEF) begin
            failures++; $display("FAIL load_write got=%b/%0d/%h exp=1/7/deadbeef", wb_wen, wb_waddr, wb_wdata);
        end
        if (ex_rs1_fwd !== 32'hDEADBEEF) begin failures++; $display("FAIL load_fwd got=%h exp=deadbeef", ex_rs1_fwd); end
        exp_instret++;
        tick();
        checks++;
        if (instret !== exp_instret) begin failures++; $display("FAIL load_instret got=%0d exp=%0d", instret, exp_instret); end
    endtask

    task automatic test_x0_target;
        issue(WB_SRC_ALU, 5'd0, 32'h55);
        tick();
        idle();
        ex_rs1_addr = 0; ex_rs1_rf = 32'h99;
        #1;
        checks += 3;
        if (wb_wen !== 1'b0) begin failures++; $display("FAIL x0_wen got=%b exp=0", wb_wen); end
        if (ex_rs1_fwd !== 32'h0) begin failures++; $display("FAIL x0_fwd got=%h exp=0", ex_rs1_fwd); end
        if (wb_retire !== 1'b1) begin failures++; $display("FAIL x0_retire got=%b exp=1", wb_retire); end
        exp_instret++;
        tick();
    endtask

    task automatic test_kill;
        issue(WB_SRC_ALU, 5'd9, 32'h42);
        ex_kill = 1;
        tick();
        idle();
        ex_rs1_addr = 9; ex_rs1_rf = 32'h123;
        #1;
        checks += 3;
        if (wb_wen !== 1'b0) begin failures++; $display("FAIL kill_wen got=%b exp=0", wb_wen); end
        if (wb_retire !== 1'b0) begin failures++; $display("FAIL kill_retire got=%b exp=0", wb_retire); end
        if (ex_rs1_fwd !== 32'h123) begin failures++; $display("FAIL kill_fwd got=%h exp=123", ex_rs1_fwd); end
        issue(WB_SRC_MEM, 5'd8, 32'h0);
        dmem_wait = 1;
        tick();
        issue(WB_SRC_ALU, 5'd4, 32'h1);
        ex_kill = 1; dmem_wait = 1;
        #1;
        checks++;
        if (stall_ex !== 1'b1) begin failures++; $display("FAIL kill_stall got=%b exp=1", stall_ex); end
        tick();
        idle();
        dmem_rdata = 32'hCAFE;
        #1;
        checks++;
        if (wb_wen !== 1'b1 || wb_retire !== 1'b1 || wb_waddr !== 5'd8 || wb_wdata !== 32'hCAFE) begin
            failures++; $display("FAIL kill_in_stall got=%b/%b/%0d/%h exp=1/1/8/cafe", wb_wen, wb_retire, wb_waddr, wb_wdata);
        end
        exp_instret++;
        tick();
        checks++;
        if (instret !== exp_instret) begin failures++; $display("FAIL kill_instret got=%0d exp=%0d", instret, exp_instret); end
    endtask

    task automatic test_counter_wrap;
        issue(WB_SRC_ALU, 5'd3, 32'h7);
        tick();
        idle();
        dut.instret_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        checks++;
        if (instret !== 64'd0) begin failures++; $display("FAIL wrap_instret got=%h exp=0", instret); end
        exp_instret = 0;
    endtask

    task automatic test_reset_mid_stall;
        issue(WB_SRC_MEM, 5'd10, 32'h0);
        dmem_wait = 1;
        tick();
        idle();
        dmem_wait = 1;
        #1;
        checks++;
        if (stall_ex !== 1'b1) begin failures++; $display("FAIL rst_stall_pre got=%b exp=1", stall_ex); end
        reset_n = 0;
        tick();
        reset_n = 1;
        #1;
        checks += 3;
        if (stall_ex !== 1'b0) begin failures++; $display("FAIL rst_stall_post got=%b exp=0", stall_ex); end
        if (instret !== 64'd0) begin failures++; $display("FAIL rst_instret got=%0d exp=0", instret); end
        if (wb_wen !== 1'b0 || wb_retire !== 1'b0) begin failures++; $display("FAIL rst_write got=%b/%b exp=0/0", wb_wen, wb_retire); end
        tick();
        checks++;
        if (instret !== 64'd0) begin failures++; $display("FAIL rst_instret_hold got=%0d exp=0", instret); end
    endtask

    initial begin
        test_reset();
        test_alu_back_to_back();
        test_wb_sources();
        test_load_wait();
        test_x0_target();
        test_kill();
        test_counter_wrap();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
